// File: rtl/nvdla_dmaif_rd_arb.sv
// Multi-channel DMA read arbiter: round-robin request merge onto one memory read port,
// in-order tag tracking for response routing, and ram-type-gated credit pop forwarding.
module nvdla_dmaif_rd_arb #(
    parameter int NCH       = 2,
    parameter int REQ_PW    = 47,
    parameter int RSP_PW    = 257,
    parameter int TAG_DEPTH = 16
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic [NCH*REQ_PW-1:0] ch_req_pd,
    input  logic [NCH-1:0]        ch_req_vld,
    output logic [NCH-1:0]        ch_req_rdy,
    output logic [RSP_PW-1:0]     ch_rsp_pd,
    output logic [NCH-1:0]        ch_rsp_vld,
    input  logic [NCH-1:0]        ch_rsp_rdy,
    input  logic [NCH-1:0]        ch_ram_type,
    input  logic [NCH-1:0]        ch_cdt_pop,
    output logic [REQ_PW-1:0]     mem_rd_req_pd,
    output logic                  mem_rd_req_valid,
    input  logic                  mem_rd_req_ready,
    input  logic [RSP_PW-1:0]     mem_rd_rsp_pd,
    input  logic                  mem_rd_rsp_valid,
    output logic                  mem_rd_rsp_ready,
    output logic                  mem_rd_cdt_lat_fifo_pop
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TAW = $clog2(TAG_DEPTH);
    localparam int TW  = CHW + 15;

    logic                req_vld_q;
    logic [REQ_PW-1:0]   req_pd_q;
    logic                cdt_q;
    logic [CHW-1:0]      rr_q, rr_d;
    logic [14:0]         bcnt_q;
    logic [TW-1:0]       tag_mem_q [TAG_DEPTH];
    logic [TAW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [TAW:0]        cnt_q;

    logic                tag_empty, tag_full, loadable;
    logic [2*NCH-1:0]    vld_rot;
    logic [CHW-1:0]      off, gidx;
    logic [CHW:0]        gsum;
    logic                found, accept;
    logic [NCH-1:0]      grant;
    logic [REQ_PW-1:0]   acc_pd;
    logic [14:0]         acc_size;
    logic [TW-1:0]       head;
    logic [CHW-1:0]      head_ch;
    logic [14:0]         head_size;
    logic                sel_rdy, rsp_hs, last_beat;

    assign tag_empty = (cnt_q == '0);
    assign tag_full  = (cnt_q == (TAW+1)'(TAG_DEPTH));
    assign loadable  = !req_vld_q || mem_rd_req_ready;

    // Rotate the valid vector so bit 0 is the rr position; lowest set bit wins.
    assign vld_rot = {ch_req_vld, ch_req_vld} >> rr_q;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int unsigned k = NCH; k > 0; k--) begin
            if (vld_rot[k-1]) begin
                found = 1'b1;
                off   = CHW'(k - 1);
            end
        end
        gsum = {1'b0, rr_q} + {1'b0, off};
        if (gsum >= (CHW+1)'(NCH)) gsum = gsum - (CHW+1)'(NCH);
        gidx   = gsum[CHW-1:0];
        accept = found && loadable && !tag_full;
        grant  = '0;
        acc_pd = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gidx == CHW'(i)) begin
                grant[i] = accept;
                acc_pd   = ch_req_pd[i*REQ_PW +: REQ_PW];
            end
        end
        acc_size = acc_pd[REQ_PW-1 -: 15];
        rr_d     = (gidx == CHW'(NCH - 1)) ? '0 : gidx + 1'b1;
    end

    assign ch_req_rdy = grant;

    assign head      = tag_mem_q[rd_ptr_q];
    assign head_ch   = head[TW-1 -: CHW];
    assign head_size = head[14:0];

    always_comb begin
        sel_rdy    = 1'b0;
        ch_rsp_vld = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (head_ch == CHW'(i)) begin
                ch_rsp_vld[i] = mem_rd_rsp_valid && !tag_empty;
                sel_rdy       = ch_rsp_rdy[i];
            end
        end
    end

    assign mem_rd_rsp_ready = !tag_empty && sel_rdy;
    assign ch_rsp_pd        = mem_rd_rsp_pd;
    assign rsp_hs           = mem_rd_rsp_valid && mem_rd_rsp_ready;
    assign last_beat        = rsp_hs && (bcnt_q == head_size);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            req_vld_q <= 1'b0;
            req_pd_q  <= '0;
            cdt_q     <= 1'b0;
            rr_q      <= '0;
            bcnt_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                req_vld_q <= 1'b1;
                req_pd_q  <= acc_pd;
                rr_q      <= rr_d;
                wr_ptr_q  <= wr_ptr_q + 1'b1;
            end else if (mem_rd_req_ready) begin
                req_vld_q <= 1'b0;
            end
            if (rsp_hs) begin
                bcnt_q <= last_beat ? '0 : bcnt_q + 1'b1;
            end
            if (last_beat) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({accept, last_beat})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            cdt_q <= |(ch_cdt_pop & ch_ram_type);
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (accept) tag_mem_q[wr_ptr_q] <= {gidx, acc_size};
    end

    assign mem_rd_req_valid        = req_vld_q;
    assign mem_rd_req_pd           = req_pd_q;
    assign mem_rd_cdt_lat_fifo_pop = cdt_q;

endmodule

// File: tb/tb_nvdla_dmaif_rd_arb.sv
// Bench for nvdla_dmaif_rd_arb: directed scenarios then random traffic, each cycle
// checked against a transaction-level model (tag queue with remaining-beat counts).
module tb_nvdla_dmaif_rd_arb;

    localparam int NCH       = 3;
    localparam int REQ_PW    = 47;
    localparam int RSP_PW    = 64;
    localparam int TAG_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [NCH*REQ_PW-1:0] ch_req_pd = '0;
    logic [NCH-1:0]        ch_req_vld = '0;
    logic [NCH-1:0]        ch_req_rdy;
    logic [RSP_PW-1:0]     ch_rsp_pd;
    logic [NCH-1:0]        ch_rsp_vld;
    logic [NCH-1:0]        ch_rsp_rdy = '0;
    logic [NCH-1:0]        ch_ram_type = '0;
    logic [NCH-1:0]        ch_cdt_pop = '0;
    logic [REQ_PW-1:0]     mem_rd_req_pd;
    logic                  mem_rd_req_valid;
    logic                  mem_rd_req_ready = 1'b0;
    logic [RSP_PW-1:0]     mem_rd_rsp_pd = '0;
    logic                  mem_rd_rsp_valid = 1'b0;
    logic                  mem_rd_rsp_ready;
    logic                  mem_rd_cdt_lat_fifo_pop;

    nvdla_dmaif_rd_arb #(
        .NCH(NCH), .REQ_PW(REQ_PW), .RSP_PW(RSP_PW), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rstn(rstn),
        .ch_req_pd(ch_req_pd),
        .ch_req_vld(ch_req_vld),
        .ch_req_rdy(ch_req_rdy),
        .ch_rsp_pd(ch_rsp_pd),
        .ch_rsp_vld(ch_rsp_vld),
        .ch_rsp_rdy(ch_rsp_rdy),
        .ch_ram_type(ch_ram_type),
        .ch_cdt_pop(ch_cdt_pop),
        .mem_rd_req_pd(mem_rd_req_pd),
        .mem_rd_req_valid(mem_rd_req_valid),
        .mem_rd_req_ready(mem_rd_req_ready),
        .mem_rd_rsp_pd(mem_rd_rsp_pd),
        .mem_rd_rsp_valid(mem_rd_rsp_valid),
        .mem_rd_rsp_ready(mem_rd_rsp_ready),
        .mem_rd_cdt_lat_fifo_pop(mem_rd_cdt_lat_fifo_pop)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int left; } tag_t;
    tag_t              tq[$];
    int                rr;
    logic              m_vld;
    logic [REQ_PW-1:0] m_pd;
    logic              m_cdt;
    int                n_cmp = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        tq.delete();
        rr    = 0;
        m_vld = 1'b0;
        m_pd  = '0;
        m_cdt = 1'b0;
    endtask

    task automatic clear_inputs();
        ch_req_vld       = '0;
        ch_rsp_rdy       = '0;
        ch_cdt_pop       = '0;
        ch_ram_type      = '0;
        mem_rd_req_ready = 1'b0;
        mem_rd_rsp_valid = 1'b0;
    endtask

    task automatic set_ch(input int c, input bit v, input int size);
        ch_req_vld[c] = v;
        ch_req_pd[c*REQ_PW +: REQ_PW] = {15'(size), 32'($urandom)};
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, advances model at the edge.
    task automatic cycle();
        int g;
        bit loadable;
        logic [NCH-1:0] e_rdy, e_rvld;
        logic e_rrdy;
        @(negedge clk);
        g = -1;
        loadable = !m_vld || mem_rd_req_ready;
        if (loadable && tq.size() < TAG_DEPTH)
            for (int k = 0; k < NCH; k++) begin
                int c = (rr + k) % NCH;
                if (g < 0 && ch_req_vld[c]) g = c;
            end
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rvld = '0;
        e_rrdy = 1'b0;
        if (tq.size() > 0) begin
            e_rvld[tq[0].ch] = mem_rd_rsp_valid;
            e_rrdy = ch_rsp_rdy[tq[0].ch];
        end
        chk("ch_req_rdy", 64'(ch_req_rdy), 64'(e_rdy));
        chk("mem_rd_req_valid", 64'(mem_rd_req_valid), 64'(m_vld));
        chk("mem_rd_req_pd", 64'(mem_rd_req_pd), 64'(m_pd));
        chk("ch_rsp_vld", 64'(ch_rsp_vld), 64'(e_rvld));
        chk("mem_rd_rsp_ready", 64'(mem_rd_rsp_ready), 64'(e_rrdy));
        chk("ch_rsp_pd", 64'(ch_rsp_pd), 64'(mem_rd_rsp_pd));
        chk("cdt_pop", 64'(mem_rd_cdt_lat_fifo_pop), 64'(m_cdt));
        @(posedge clk);
        if (tq.size() > 0 && mem_rd_rsp_valid && e_rrdy) begin
            tq[0].left--;
            if (tq[0].left == 0) void'(tq.pop_front());
        end
        if (g >= 0) begin
            m_pd  = ch_req_pd[g*REQ_PW +: REQ_PW];
            m_vld = 1'b1;
            rr    = (g + 1) % NCH;
            tq.push_back('{ch: g, left: int'(m_pd[REQ_PW-1 -: 15]) + 1});
        end else if (mem_rd_req_ready) begin
            m_vld = 1'b0;
        end
        m_cdt = |(ch_cdt_pop & ch_ram_type);
        #1;
    endtask

    // Reset is dropped mid-cycle to exercise the asynchronous clear.
    task automatic do_reset();
        #3 rstn = 1'b0;
        #1;
        chk("rst_req_valid", 64'(mem_rd_req_valid), 64'd0);
        chk("rst_req_pd", 64'(mem_rd_req_pd), 64'd0);
        chk("rst_cdt", 64'(mem_rd_cdt_lat_fifo_pop), 64'd0);
        chk("rst_rsp_vld", 64'(ch_rsp_vld), 64'd0);
        chk("rst_rsp_ready", 64'(mem_rd_rsp_ready), 64'd0);
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // All channels requesting, size 0, drained every cycle: grants rotate 0,1,2,...
        mem_rd_req_ready = 1'b1;
        mem_rd_rsp_valid = 1'b1;
        ch_rsp_rdy       = '1;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, 0);
            mem_rd_rsp_pd = {$urandom, $urandom};
            #2;
            chk("rr_order", 64'(ch_req_rdy), 64'(1 << (i % 3)));
            cycle();
        end

        // Single channel, 4-beat burst.
        do_reset();
        mem_rd_req_ready = 1'b1;
        set_ch(0, 1'b1, 3);
        cycle();
        ch_req_vld = '0;
        mem_rd_rsp_valid = 1'b1;
        ch_rsp_rdy = 3'b001;
        for (int i = 0; i < 6; i++) begin
            mem_rd_rsp_pd = {$urandom, $urandom};
            cycle();
        end

        // Request back-pressure for 5 cycles.
        set_ch(0, 1'b1, 0);
        cycle();
        ch_req_vld = '0;
        set_ch(1, 1'b1, 0);
        mem_rd_req_ready = 1'b0;
        repeat (5) cycle();
        mem_rd_req_ready = 1'b1;
        repeat (2) cycle();
        ch_req_vld = '0;
        repeat (3) cycle();

        // Tag FIFO fill: 4 accepted, 5th blocked until a beat returns (no bypass).
        do_reset();
        mem_rd_req_ready = 1'b1;
        ch_rsp_rdy = '1;
        for (int i = 0; i < 6; i++) begin
            set_ch(2, 1'b1, 0);
            cycle();
        end
        chk("tag_full_block", 64'(ch_req_rdy), 64'd0);
        mem_rd_rsp_valid = 1'b1;
        cycle();
        mem_rd_rsp_valid = 1'b0;
        repeat (2) cycle();

        // Interleaved channels with a response stall on ch1.
        do_reset();
        mem_rd_req_ready = 1'b1;
        set_ch(1, 1'b1, 1);
        cycle();
        ch_req_vld = '0;
        set_ch(0, 1'b1, 0);
        cycle();
        ch_req_vld = '0;
        mem_rd_rsp_valid = 1'b1;
        ch_rsp_rdy = 3'b001;
        repeat (2) cycle();
        ch_rsp_rdy = 3'b111;
        repeat (4) cycle();

        // Credit pop gating by ram type.
        ch_cdt_pop  = 3'b011;
        ch_ram_type = 3'b010;
        cycle();
        ch_ram_type = 3'b000;
        cycle();
        ch_cdt_pop = '0;
        cycle();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++) set_ch(c, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            mem_rd_req_ready = ($urandom_range(0, 3) != 0);
            mem_rd_rsp_valid = 1'($urandom_range(0, 1));
            mem_rd_rsp_pd    = {$urandom, $urandom};
            ch_rsp_rdy       = NCH'($urandom);
            ch_cdt_pop       = NCH'($urandom);
            ch_ram_type      = NCH'($urandom);
            cycle();
        end

        // Reset lands mid-burst with traffic still applied.
        do_reset();
        mem_rd_req_ready = 1'b1;
        set_ch(1, 1'b1, 2);
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
